// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler binding ready reservation-station entries to three integer ALUs.
// Optional macro ALU_MEM_PIN_EN restricts memory optypes (7..10) to ALU 0.
module alu_issue_scheduler #(
  parameter int NUM_RS   = 16,
  parameter int RS_IDX_W = 4,
  parameter int NUM_ALU  = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [NUM_RS-1:0]            rs_req,
  input  logic [NUM_RS*4-1:0]          rs_optype,
  output logic [NUM_RS-1:0]            rs_grant,
  input  logic [NUM_ALU-1:0]           wb_ack,
  output logic [NUM_ALU-1:0]           issue_valid,
  output logic [NUM_ALU*4-1:0]         issue_optype,
  output logic [NUM_ALU*RS_IDX_W-1:0]  issue_rs_idx,
  output logic [NUM_ALU*2-1:0]         issue_alu_number,
  output logic [NUM_ALU-1:0]           alu_free,
  output logic                         err_optype
);

  logic [NUM_ALU-1:0]          r_valid;
  logic [NUM_ALU*4-1:0]        r_optype;
  logic [NUM_ALU*RS_IDX_W-1:0] r_rs_idx;
  logic [NUM_ALU*2-1:0]        r_alu_num;
  logic [RS_IDX_W-1:0]         r_rr_ptr;
  logic                        r_err;

  logic [NUM_ALU-1:0]          w_free;
  logic [NUM_RS-1:0]           w_grant;
  logic [NUM_ALU-1:0]          w_alu_gnt;
  logic [NUM_ALU*RS_IDX_W-1:0] w_alu_src;
  logic [NUM_ALU*4-1:0]        w_alu_op;
  logic                        w_any;
  logic                        w_illegal;
  logic [RS_IDX_W-1:0]         w_last;
  logic [RS_IDX_W-1:0]         w_rr_next;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd10);
  endfunction

`ifdef ALU_MEM_PIN_EN
  function automatic logic is_mem(input logic [3:0] op);
    return (op >= 4'd7) && (op <= 4'd10);
  endfunction
`endif

  assign w_free           = ~r_valid | wb_ack;
  assign alu_free         = w_free;
  assign rs_grant         = w_grant;
  assign issue_valid      = r_valid;
  assign issue_optype     = r_optype;
  assign issue_rs_idx     = r_rs_idx;
  assign issue_alu_number = r_alu_num;
  assign err_optype       = r_err;
  assign w_rr_next        = (w_last == RS_IDX_W'(NUM_RS - 1)) ? {RS_IDX_W{1'b0}} : w_last + 1'b1;

  // Scan from r_rr_ptr, binding each eligible request to the lowest free, still-unclaimed ALU
  always_comb begin
    logic [RS_IDX_W-1:0] v_idx;
    logic [3:0]          v_op;
    logic                v_placed;
    logic                v_mem_only;
    w_grant    = '0;
    w_alu_gnt  = '0;
    w_alu_src  = '0;
    w_alu_op   = '0;
    w_any      = 1'b0;
    w_last     = '0;
    w_illegal  = 1'b0;
    v_idx      = '0;
    v_op       = 4'd0;
    v_placed   = 1'b0;
    v_mem_only = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (rs_req[k] && !is_legal(rs_optype[k*4 +: 4])) begin
        w_illegal = 1'b1;
      end else begin
        w_illegal = w_illegal;
      end
    end
    if (rstn && !flush) begin
      for (int i = 0; i < NUM_RS; i++) begin
        v_idx = RS_IDX_W'((int'(r_rr_ptr) + i) % NUM_RS);
        v_op  = rs_optype[v_idx*4 +: 4];
`ifdef ALU_MEM_PIN_EN
        v_mem_only = is_mem(v_op);
`else
        v_mem_only = 1'b0;
`endif
        v_placed = 1'b0;
        if (rs_req[v_idx] && is_legal(v_op)) begin
          for (int a = 0; a < NUM_ALU; a++) begin
            if (!v_placed && w_free[a] && !w_alu_gnt[a] && (a == 0 || !v_mem_only)) begin
              v_placed                            = 1'b1;
              w_alu_gnt[a]                        = 1'b1;
              w_alu_src[a*RS_IDX_W +: RS_IDX_W]   = v_idx;
              w_alu_op[a*4 +: 4]                  = v_op;
              w_grant[v_idx]                      = 1'b1;
              w_any                               = 1'b1;
              w_last                              = v_idx;
            end else begin
              v_placed = v_placed;
            end
          end
        end else begin
          v_placed = 1'b0;
        end
      end
    end else begin
      w_grant   = '0;
      w_alu_gnt = '0;
    end
  end

  // Per-ALU occupancy, issue fields, round-robin pointer and sticky error flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid   <= '0;
      r_optype  <= '0;
      r_rs_idx  <= '0;
      r_alu_num <= '1;
      r_rr_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= r_err | w_illegal;
      if (flush) begin
        r_valid   <= '0;
        r_alu_num <= '1;
      end else begin
        for (int a = 0; a < NUM_ALU; a++) begin
          if (w_alu_gnt[a]) begin
            r_valid[a]                       <= 1'b1;
            r_optype[a*4 +: 4]               <= w_alu_op[a*4 +: 4];
            r_rs_idx[a*RS_IDX_W +: RS_IDX_W] <= w_alu_src[a*RS_IDX_W +: RS_IDX_W];
            r_alu_num[a*2 +: 2]              <= 2'(a);
          end else if (wb_ack[a]) begin
            r_valid[a]          <= 1'b0;
            r_alu_num[a*2 +: 2] <= 2'b11;
          end
        end
        if (w_any) begin
          r_rr_ptr <= w_rr_next;
        end
      end
    end
  end

endmodule
